game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level game-flow controller for the VGA space-invaders design. Sits beside
//  the vga640x480 datapath: debounces btnU, sequences attract/play/respawn/
//  level-up/game-over, and owns lives, score and level. Gates the datapath via
//  play_en, re-initialises the playfield via field_rst, and forwards fire presses.
// PARAMETERS
//  LIVES_INIT      3    lives loaded at new game (1..15)
//  DEB_TICKS       4    game_tick count btnU must be stable before a level is accepted
//  HOLD_TICKS      60   game_tick count spent in RESPAWN / LEVEL_UP / GAME_OVER hold
//  KILL_POINTS     10   score added per invader_killed pulse
// PORTS
//  clk             in   1   100 MHz system clock
//  clr             in   1   reset, asynchronous, active-high
//  game_tick       in   1   1-cycle enable from clockdiv (game rate)
//  btnU            in   1   raw up button: start game / fire
//  invader_killed  in   1   1-cycle pulse from datapath
//  player_hit      in   1   1-cycle pulse from datapath
//  wave_cleared    in   1   1-cycle pulse: no invaders remain
//  invaders_landed in   1   1-cycle pulse: invader reached player row
//  play_en         out  1   high only in PLAY; datapath freezes when low
//  field_rst       out  1   1-cycle pulse: reload invader grid and player position
//  fire            out  1   1-cycle pulse: debounced btnU press while in PLAY
//  state           out  3   0 IDLE,1 PLAY,2 RESPAWN,3 LEVEL_UP,4 GAME_OVER
//  lives           out  4   remaining lives
//  score           out  16  binary score, saturating
//  level           out  4   current wave, saturating at 15
// BEHAVIOUR
//  Reset: reset clr, asynchronous, active-high; clock clk. All outputs 0,
//   state=IDLE, hold counter 0, debouncer stable level 0.
//  Debounce: btnU through 2-FF synchroniser; on game_tick, if sync != stable
//   increment cnt else clear cnt; cnt reaching DEB_TICKS sets stable=sync, cnt=0.
//   press = 1-cycle pulse on stable 0->1. Total press latency: 2 clk + DEB_TICKS ticks.
//  All outputs registered. Datapath event pulses honoured only when state=PLAY.
//  IDLE: press -> PLAY; same edge: field_rst=1, lives=LIVES_INIT, score=0, level=0.
//  PLAY: fire=press (1 clk after press pulse). Same-cycle priority:
//   1 invaders_landed -> GAME_OVER, lives=0.
//   2 player_hit: lives-1; if lives was 1 -> GAME_OVER else -> RESPAWN.
//   3 wave_cleared -> LEVEL_UP; level+1 (hold at 15).
//   invader_killed adds KILL_POINTS in PLAY regardless of 1-3 (same cycle),
//   score saturates at 16'hFFFF (no wrap).
//  RESPAWN: hold cnt counts game_ticks; at HOLD_TICKS -> PLAY, no field_rst.
//  LEVEL_UP: same hold; at HOLD_TICKS -> PLAY with field_rst=1 on that edge.
//  GAME_OVER: lives/score/level frozen for display; presses ignored until
//   HOLD_TICKS ticks elapsed; then press -> PLAY exactly as from IDLE.
//  Hold cnt cleared on every state entry; press/fire never emitted outside PLAY.
//  play_en = (state==PLAY), registered with state (no extra latency).
//  clr mid-game: immediate return to reset values; no field_rst pulse emitted.
// TESTING
//  T1 reset: clr=1 async mid-cycle -> state=0, play_en=0, lives=0, score=0.
//  T2 bounce: btnU toggles every tick for 10 ticks then stays 1 -> exactly one
//     start, state=1, field_rst one clk wide, lives=3, level=0.
//  T3 scoring: 3 invader_killed in PLAY -> score=30; score preset 65530 + kill
//     -> 65535; kill pulse in RESPAWN -> score unchanged.
//  T4 lives: player_hit x3 with HOLD_TICKS waits -> lives 2,1 via RESPAWN,
//     third hit -> state=4, lives=0; press before 60 ticks ignored, after -> PLAY.
//  T5 same-cycle: player_hit+wave_cleared -> RESPAWN, level unchanged;
//     invaders_landed+player_hit -> GAME_OVER, lives=0.
//  T6 level: wave_cleared -> state=3, level=1, play_en=0; after 60 ticks
//     state=1, field_rst single pulse; repeat 16x -> level holds at 15.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Connection bundle between the game-flow sequencer and the rest of the VGA design.
// master drives the datapath events and the button; slave is the sequencer itself.
interface game_sequencer_if;
  logic        game_tick;
  logic        btnU;
  logic        invader_killed;
  logic        player_hit;
  logic        wave_cleared;
  logic        invaders_landed;
  logic        play_en;
  logic        field_rst;
  logic        fire;
  logic [2:0]  state;
  logic [3:0]  lives;
  logic [15:0] score;
  logic [3:0]  level;

  modport master (
    output game_tick, btnU, invader_killed, player_hit, wave_cleared, invaders_landed,
    input  play_en, field_rst, fire, state, lives, score, level
  );

  modport slave (
    input  game_tick, btnU, invader_killed, player_hit, wave_cleared, invaders_landed,
    output play_en, field_rst, fire, state, lives, score, level
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: debounces btnU and walks attract/play/respawn/level-up/game-over,
// owning lives, score and level and gating the datapath through play_en and field_rst.
module game_sequencer #(
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned DEB_TICKS   = 4,
  parameter int unsigned HOLD_TICKS  = 60,
  parameter int unsigned KILL_POINTS = 10
) (
  input  logic             clk,
  input  logic             clr,
  game_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_RESPAWN   = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          press_q, press_d;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    lives_q, lives_d;
  logic [15:0]   score_q, score_d;
  logic [3:0]    level_q, level_d;
  logic          play_en_q, play_en_d;
  logic          field_rst_q, field_rst_d;
  logic          fire_q, fire_d;

  logic [16:0]   score_sum;
  logic          hold_last;
  logic          hold_full;

  assign score_sum = {1'b0, score_q} + 17'(KILL_POINTS);
  assign hold_last = bus.game_tick && (hold_q == HW'(HOLD_TICKS - 1));
  assign hold_full = (hold_q == HW'(HOLD_TICKS));

  always_comb begin
    sync1_d     = bus.btnU;
    sync2_d     = sync1_q;
    stable_d    = stable_q;
    deb_cnt_d   = deb_cnt_q;
    state_d     = state_q;
    hold_d      = hold_q;
    lives_d     = lives_q;
    score_d     = score_q;
    level_d     = level_q;
    field_rst_d = 1'b0;
    fire_d      = 1'b0;

    // The synchronised level must disagree with the stable level for DEB_TICKS consecutive ticks.
    if (bus.game_tick) begin
      if (sync2_q != stable_q) begin
        if (deb_cnt_q == DW'(DEB_TICKS - 1)) begin
          stable_d  = sync2_q;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end else begin
        deb_cnt_d = '0;
      end
    end
    press_d = stable_d && !stable_q;

    if (bus.game_tick && !hold_full) begin
      hold_d = hold_q + HW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (press_q) begin
          state_d     = S_PLAY;
          field_rst_d = 1'b1;
          lives_d     = 4'(LIVES_INIT);
          score_d     = '0;
          level_d     = '0;
        end
      end
      S_PLAY: begin
        fire_d = press_q;
        if (bus.invader_killed) begin
          score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
        if (bus.invaders_landed) begin
          state_d = S_GAME_OVER;
          lives_d = '0;
        end else if (bus.player_hit) begin
          lives_d = lives_q - 4'd1;
          state_d = (lives_q == 4'd1) ? S_GAME_OVER : S_RESPAWN;
        end else if (bus.wave_cleared) begin
          state_d = S_LEVEL_UP;
          level_d = (level_q == 4'hF) ? 4'hF : level_q + 4'd1;
        end
      end
      S_RESPAWN: begin
        if (hold_last) begin
          state_d = S_PLAY;
        end
      end
      S_LEVEL_UP: begin
        if (hold_last) begin
          state_d     = S_PLAY;
          field_rst_d = 1'b1;
        end
      end
      S_GAME_OVER: begin
        // Final lives/score/level stay on display until a new game is started.
        if (hold_full && press_q) begin
          state_d     = S_PLAY;
          field_rst_d = 1'b1;
          lives_d     = 4'(LIVES_INIT);
          score_d     = '0;
          level_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      hold_d = '0;
    end
    play_en_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
      state_q     <= S_IDLE;
      hold_q      <= '0;
      lives_q     <= '0;
      score_q     <= '0;
      level_q     <= '0;
      play_en_q   <= 1'b0;
      field_rst_q <= 1'b0;
      fire_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      deb_cnt_q   <= deb_cnt_d;
      press_q     <= press_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      level_q     <= level_d;
      play_en_q   <= play_en_d;
      field_rst_q <= field_rst_d;
      fire_q      <= fire_d;
    end
  end

  assign bus.play_en   = play_en_q;
  assign bus.field_rst = field_rst_q;
  assign bus.fire      = fire_q;
  assign bus.state     = state_q;
  assign bus.lives     = lives_q;
  assign bus.score     = score_q;
  assign bus.level     = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expected status snapshots and
// pulses; an independent monitor compares them against the DUT one cycle at a time.
module tb_game_sequencer;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  game_sequencer_if bus ();

  game_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [3:0]  lv;
    logic [15:0] sc;
    logic [3:0]  le;
    logic        pe;
  } status_t;

  typedef struct {
    string      name;
    logic [3:0] lv;
    logic [3:0] le;
  } frst_t;

  status_t status_q[$];
  frst_t   frst_q[$];
  string   fire_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // game_tick is high every other clock cycle
  initial begin
    bus.game_tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.game_tick = ~bus.game_tick;
    end
  end

  // Monitor: sample 1 ns after the active edge and compare against the scoreboard.
  initial begin
    status_t s;
    frst_t   f;
    string   fn;
    checks = 0;
    errors = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.field_rst === 1'b1) begin
        checks++;
        if (frst_q.size() == 0) begin
          errors++;
          $display("FAIL field_rst_unexpected: got pulse in state=%0d, required no pulse", bus.state);
        end else begin
          f = frst_q.pop_front();
          if (bus.state !== 3'd1 || bus.lives !== f.lv || bus.level !== f.le) begin
            errors++;
            $display("FAIL %s: got state=%0d lives=%0d level=%0d, required state=1 lives=%0d level=%0d",
                     f.name, bus.state, bus.lives, bus.level, f.lv, f.le);
          end else begin
            $display("pulse %s: field_rst ok lives=%0d level=%0d", f.name, bus.lives, bus.level);
          end
        end
      end
      if (bus.fire === 1'b1) begin
        checks++;
        if (fire_q.size() == 0) begin
          errors++;
          $display("FAIL fire_unexpected: got pulse in state=%0d, required no pulse", bus.state);
        end else begin
          fn = fire_q.pop_front();
          if (bus.state !== 3'd1) begin
            errors++;
            $display("FAIL %s: got fire in state=%0d, required state=1", fn, bus.state);
          end else begin
            $display("pulse %s: fire ok", fn);
          end
        end
      end
      if (status_q.size() > 0) begin
        s = status_q.pop_front();
        checks++;
        if (bus.state !== s.st || bus.lives !== s.lv || bus.score !== s.sc ||
            bus.level !== s.le || bus.play_en !== s.pe) begin
          errors++;
          $display("FAIL %s: got state=%0d lives=%0d score=%0d level=%0d play_en=%0d, required state=%0d lives=%0d score=%0d level=%0d play_en=%0d",
                   s.name, bus.state, bus.lives, bus.score, bus.level, bus.play_en,
                   s.st, s.lv, s.sc, s.le, s.pe);
        end else begin
          $display("check %s: state=%0d lives=%0d score=%0d level=%0d play_en=%0d",
                   s.name, bus.state, bus.lives, bus.score, bus.level, bus.play_en);
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  // m = {invaders_landed, player_hit, wave_cleared, invader_killed}
  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    bus.invaders_landed = m[3];
    bus.player_hit      = m[2];
    bus.wave_cleared    = m[1];
    bus.invader_killed  = m[0];
    @(negedge clk);
    bus.invaders_landed = 1'b0;
    bus.player_hit      = 1'b0;
    bus.wave_cleared    = 1'b0;
    bus.invader_killed  = 1'b0;
  endtask

  task automatic press();
    bus.btnU = 1'b1;
    wait_ticks(8);
    bus.btnU = 1'b0;
    wait_ticks(8);
  endtask

  task automatic expect_st(input string n, input int st, input int lv, input int sc,
                           input int le, input int pe);
    status_t s;
    s.name = n;
    s.st   = 3'(st);
    s.lv   = 4'(lv);
    s.sc   = 16'(sc);
    s.le   = 4'(le);
    s.pe   = 1'(pe);
    status_q.push_back(s);
    @(negedge clk);
  endtask

  task automatic expect_frst(input string n, input int lv, input int le);
    frst_t f;
    f.name = n;
    f.lv   = 4'(lv);
    f.le   = 4'(le);
    frst_q.push_back(f);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_le;
    clr                 = 1'b1;
    bus.btnU            = 1'b0;
    bus.invader_killed  = 1'b0;
    bus.player_hit      = 1'b0;
    bus.wave_cleared    = 1'b0;
    bus.invaders_landed = 1'b0;
    repeat (3) @(negedge clk);
    expect_st("reset_held", 0, 0, 0, 0, 0);
    clr = 1'b0;
    expect_st("reset_released", 0, 0, 0, 0, 0);
    wait_ticks(4);
    expect_st("idle_stays", 0, 0, 0, 0, 0);

    // Bouncing button: only the final steady level may start the game, exactly once.
    expect_frst("start_bounce", 3, 0);
    for (int i = 0; i < 10; i++) begin
      bus.btnU = (i % 2 == 0);
      wait_ticks(1);
    end
    bus.btnU = 1'b1;
    wait_ticks(10);
    expect_st("start_play", 1, 3, 0, 0, 1);
    bus.btnU = 1'b0;
    wait_ticks(8);

    fire_q.push_back("fire_in_play");
    press();

    for (int i = 0; i < 3; i++) pulse(4'b0001);
    expect_st("score_3_kills", 1, 3, 30, 0, 1);

    // hit and clear together: hit wins, level untouched
    pulse(4'b0110);
    expect_st("hit_clear_respawn", 2, 2, 30, 0, 0);
    pulse(4'b0001);
    expect_st("kill_in_respawn", 2, 2, 30, 0, 0);
    wait_ticks(55);
    expect_st("respawn_holding", 2, 2, 30, 0, 0);
    wait_ticks(8);
    expect_st("respawn_to_play", 1, 2, 30, 0, 1);

    for (int i = 1; i <= 16; i++) begin
      exp_le = (i > 15) ? 15 : i;
      pulse(4'b0010);
      expect_st($sformatf("level_up_%0d", i), 3, 2, 30, exp_le, 0);
      expect_frst($sformatf("level_rst_%0d", i), 2, exp_le);
      wait_ticks(65);
      expect_st($sformatf("level_play_%0d", i), 1, 2, 30, exp_le, 1);
    end

    // 6550 kills from 30 reach 65530, then the next kill saturates
    @(negedge clk);
    bus.invader_killed = 1'b1;
    repeat (6550) @(negedge clk);
    bus.invader_killed = 1'b0;
    expect_st("score_65530", 1, 2, 65530, 15, 1);
    pulse(4'b0001);
    expect_st("score_saturate", 1, 2, 65535, 15, 1);
    pulse(4'b0001);
    expect_st("score_hold_max", 1, 2, 65535, 15, 1);

    pulse(4'b0100);
    expect_st("hit_to_1", 2, 1, 65535, 15, 0);
    wait_ticks(65);
    expect_st("respawn_play_1", 1, 1, 65535, 15, 1);
    pulse(4'b0100);
    expect_st("last_life_over", 4, 0, 65535, 15, 0);
    pulse(4'b0001);
    expect_st("kill_in_over", 4, 0, 65535, 15, 0);
    press();
    expect_st("early_press_ignored", 4, 0, 65535, 15, 0);
    wait_ticks(50);
    expect_frst("restart_1", 3, 0);
    press();
    expect_st("restart_play", 1, 3, 0, 0, 1);

    pulse(4'b0100);
    expect_st("hit_a", 2, 2, 0, 0, 0);
    wait_ticks(65);
    pulse(4'b0100);
    expect_st("hit_b", 2, 1, 0, 0, 0);
    wait_ticks(65);
    pulse(4'b0100);
    expect_st("hit_c_over", 4, 0, 0, 0, 0);
    wait_ticks(65);
    expect_frst("restart_2", 3, 0);
    press();
    expect_st("restart2_play", 1, 3, 0, 0, 1);

    pulse(4'b0001);
    expect_st("kill_after_restart", 1, 3, 10, 0, 1);
    pulse(4'b1100);
    expect_st("landed_hit_over", 4, 0, 10, 0, 0);
    wait_ticks(65);
    expect_frst("restart_3", 3, 0);
    press();
    expect_st("restart3_play", 1, 3, 0, 0, 1);
    pulse(4'b0001);
    expect_st("kill_before_clr", 1, 3, 10, 0, 1);

    // asynchronous clear in the middle of a cycle
    @(posedge clk);
    #3;
    clr = 1'b1;
    @(negedge clk);
    expect_st("midgame_clr", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    wait_ticks(3);
    expect_st("after_clr_idle", 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (frst_q.size() != 0 || fire_q.size() != 0 || status_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got field_rst=%0d fire=%0d status=%0d left, required 0",
               frst_q.size(), fire_q.size(), status_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
